// File: rtl/sr_pkg.sv
// Shared definitions for the SR command controller and the downstream SR flip-flop stage.
package sr_pkg;

    typedef enum logic [1:0] {
        StIdle,
        StPulse,
        StHoldoff
    } sr_state_e;

    // {s, r} command encoding shared with the flip-flop stage.
    typedef logic [1:0] sr_cmd_t;

    localparam sr_cmd_t CmdHold    = 2'b00;
    localparam sr_cmd_t CmdReset   = 2'b01;
    localparam sr_cmd_t CmdSet     = 2'b10;
    localparam sr_cmd_t CmdInvalid = 2'b11;

    localparam int unsigned HoldoffW = 8;
    localparam int unsigned DebCntW  = 8;

endpackage

// File: rtl/sr_debounce.sv
// Per-button conditioning: 2-flop synchronizer, stability-count debounce and a
// registered one-cycle pulse on each rising edge of the debounced level.
module sr_debounce
    import sr_pkg::*;
#(
    parameter int unsigned DEB_CYCLES = 4
) (
    input  logic clk,
    input  logic rst_n,
    input  logic btn_i,
    output logic rise_o
);

    localparam logic [DebCntW-1:0] CntLast = DebCntW'(DEB_CYCLES - 1);

    logic               sync1_q, sync2_q;
    logic               deb_q, deb_d;
    logic               deb_prev_q;
    logic               rise_q;
    logic [DebCntW-1:0] cnt_q, cnt_d;

    // Any sample that agrees with the debounced level clears the stability count.
    always_comb begin
        deb_d = deb_q;
        cnt_d = '0;
        if (sync2_q != deb_q) begin
            if (cnt_q == CntLast) begin
                deb_d = sync2_q;
            end else begin
                cnt_d = cnt_q + 1'b1;
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sync1_q    <= 1'b0;
            sync2_q    <= 1'b0;
            deb_q      <= 1'b0;
            deb_prev_q <= 1'b0;
            cnt_q      <= '0;
            rise_q     <= 1'b0;
        end else begin
            sync1_q    <= btn_i;
            sync2_q    <= sync1_q;
            deb_q      <= deb_d;
            cnt_q      <= cnt_d;
            deb_prev_q <= deb_q;
            rise_q     <= deb_q & ~deb_prev_q;
        end
    end

    assign rise_o = rise_q;

endmodule

// File: rtl/sr_cmd_ctrl.sv
// Turns two bouncy buttons into single registered set/reset pulses for an SR
// flip-flop, with reset priority and a lockout window after each command.
module sr_cmd_ctrl
    import sr_pkg::*;
#(
    parameter int unsigned DEB_CYCLES = 4,
    parameter int unsigned HOLDOFF    = 8
) (
    input  logic clk,
    input  logic rst_n,
    input  logic set_btn,
    input  logic rst_btn,
    output logic s,
    output logic r,
    output logic conflict,
    output logic busy
);

    localparam logic [HoldoffW-1:0] HoldLoad =
        (HOLDOFF == 0) ? '0 : HoldoffW'(HOLDOFF - 1);

    logic                set_rise, rst_rise;
    sr_state_e           state_q;
    logic [HoldoffW-1:0] hold_cnt_q;
    sr_cmd_t             cmd_q;
    logic                conflict_q;
    logic                busy_q;

    sr_debounce #(
        .DEB_CYCLES(DEB_CYCLES)
    ) u_deb_set (
        .clk   (clk),
        .rst_n (rst_n),
        .btn_i (set_btn),
        .rise_o(set_rise)
    );

    sr_debounce #(
        .DEB_CYCLES(DEB_CYCLES)
    ) u_deb_rst (
        .clk   (clk),
        .rst_n (rst_n),
        .btn_i (rst_btn),
        .rise_o(rst_rise)
    );

    // Requests seen outside StIdle are simply not acted on, so nothing is queued.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q    <= StIdle;
            hold_cnt_q <= '0;
            cmd_q      <= CmdHold;
            conflict_q <= 1'b0;
            busy_q     <= 1'b0;
        end else begin
            cmd_q      <= CmdHold;
            conflict_q <= 1'b0;
            unique case (state_q)
                StIdle: begin
                    if (set_rise || rst_rise) begin
                        state_q    <= StPulse;
                        busy_q     <= 1'b1;
                        cmd_q      <= rst_rise ? CmdReset : CmdSet;
                        conflict_q <= set_rise & rst_rise;
                    end
                end
                StPulse: begin
                    if (HOLDOFF == 0) begin
                        state_q <= StIdle;
                        busy_q  <= 1'b0;
                    end else begin
                        state_q    <= StHoldoff;
                        hold_cnt_q <= HoldLoad;
                    end
                end
                StHoldoff: begin
                    if (hold_cnt_q == '0) begin
                        state_q <= StIdle;
                        busy_q  <= 1'b0;
                    end else begin
                        hold_cnt_q <= hold_cnt_q - 1'b1;
                    end
                end
                default: begin
                    state_q <= StIdle;
                    busy_q  <= 1'b0;
                end
            endcase
        end
    end

    assign s        = cmd_q[1];
    assign r        = cmd_q[0];
    assign conflict = conflict_q;
    assign busy     = busy_q;

endmodule

// File: doc/sr_cmd_ctrl.md
SR_CMD_CTRL -- requirements
Module: sr_cmd_ctrl

Interface
REQ-001 Parameter DEB_CYCLES, default 4, sets the number of consecutive stable synchronized samples needed to accept a level change (legal range 1..255).
REQ-002 Parameter HOLDOFF, default 8, sets the lockout cycles after each issued command (legal range 0..255).
REQ-003 clk  input  1  the single clock; all state updates on the rising edge.
REQ-004 rst_n  input  1  reset, asynchronous assert, active-low.
REQ-005 set_btn  input  1  raw asynchronous set request (level, may bounce).
REQ-006 rst_btn  input  1  raw asynchronous reset request (level, may bounce).
REQ-007 s  output  1  registered one-cycle set command to the downstream SR flip-flop.
REQ-008 r  output  1  registered one-cycle reset command to the downstream SR flip-flop.
REQ-009 conflict  output  1  registered one-cycle flag: set and reset accepted in the same cycle.
REQ-010 busy  output  1  registered; high while the FSM is in PULSE or HOLDOFF.

Function
REQ-011 Each raw input shall pass through a 2-flop synchronizer before any other use.
REQ-012 Debounce: the debounced level shall take the synchronized level only after that level has differed from the debounced level for DEB_CYCLES consecutive cycles; any reversion shall clear the stability count.
REQ-013 A request shall be a rising edge of a debounced level; falling edges generate nothing.
REQ-014 Latency: with a raw input held stable from before edge 0, the command output shall assert on edge DEB_CYCLES+3 and deassert one cycle later.
REQ-015 FSM states: IDLE, PULSE, HOLDOFF.
REQ-016 IDLE -> PULSE on any request; s or r is asserted for exactly the PULSE cycle.
REQ-017 PULSE -> HOLDOFF when HOLDOFF>0, else PULSE -> IDLE.
REQ-018 HOLDOFF lasts exactly HOLDOFF cycles, then -> IDLE.
REQ-019 Requests arriving in PULSE or HOLDOFF shall be dropped, not queued.
REQ-020 Simultaneous set and reset requests in IDLE: reset wins (r pulses), and conflict pulses in the same cycle as r.
REQ-021 s and r shall never be high in the same cycle (the INVALID 2'b11 code is never driven).
REQ-022 HOLDOFF counter width shall be 8 bits; it shall count down with no wrap-around past zero.
REQ-023 The debounced level continues tracking during PULSE/HOLDOFF; an edge completed during lockout is consumed and does not fire after lockout ends.

Reset
REQ-024 When rst_n is low: s=0, r=0, conflict=0, busy=0, state=IDLE, synchronizer flops=0, debounced levels=0, all counters=0.
REQ-025 Reset asserted mid-PULSE or mid-HOLDOFF shall abort immediately with no further output pulse from that command.
REQ-026 A button held high through reset release shall be treated as a new rising edge and produce one command after the REQ-014 latency.

Structure
REQ-027 Shared package sr_pkg shall hold the FSM state enum and the 2-bit {s,r} command constants HOLD=00, RESET=01, SET=10, INVALID=11, common with the flip-flop stage.
REQ-028 One sub-module, sr_debounce (synchronizer + debounce counter + rising-edge detect, parameter DEB_CYCLES), instantiated once per button.
REQ-029 sr_cmd_ctrl shall contain only the two sr_debounce instances, the FSM, the holdoff counter and the output registers.

Verification (DEB_CYCLES=4, HOLDOFF=8)
REQ-030 Clean press: set_btn 0->1 before edge 0, held -> s=1 on edge 7 only, busy high edges 7..15, r never 1.
REQ-031 Bounce: set_btn toggles every 2 cycles for 20 cycles, then stays 1 -> no s until 4 stable synchronized cycles, then exactly one s pulse.
REQ-032 Simultaneous: set_btn and rst_btn rise on the same cycle -> r=1 and conflict=1 on edge 7, s stays 0.
REQ-033 Lockout: rst_btn press, then set_btn press accepted 3 cycles after the r pulse -> no s pulse ever; a new set press after busy falls -> s pulses.
REQ-034 Reset mid-operation: rst_n low during HOLDOFF with set_btn held -> all outputs 0 immediately; after release, s pulses once on edge 7 after release.
REQ-035 HOLDOFF=0 build: two set presses with pulses 1 cycle apart -> busy high for exactly the PULSE cycle each time.
